// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction/PC widths, loader framing constant and loader FSM states.
package cpu_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned PC_W      = 8;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN,
        LD_HI,
        LD_LO,
        LD_WR,
        LD_CHK
    } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Program loader: turns a framed byte stream into instruction RAM writes and
// holds the CPU in reset until a frame with a good checksum has been loaded.
module prog_loader
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = PC_W,
    parameter int unsigned DATA_W  = INSTR_W,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        chk_q;
    logic [7:0]        hi_q;
    logic [7:0]        lo_q;
    logic [TW-1:0]     tmo_q;
    logic              cpu_rst_n_q;
    logic              err_q;
    logic              done_q;

    logic accept;
    logic counting;
    logic tmo_expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready   = (state_q != LD_WR);
        mem_we     = (state_q == LD_WR);
        busy       = (state_q != LD_IDLE);
        accept     = in_valid && in_ready;
        counting   = (state_q == LD_LEN) || (state_q == LD_HI) ||
                     (state_q == LD_LO)  || (state_q == LD_CHK);
        tmo_expire = counting && !accept && (tmo_q == TW'(TIMEOUT - 1));

        case (state_q)
            LD_IDLE: if (accept && in_data == SYNC_BYTE) state_d = LD_LEN;
            LD_LEN:  if (accept) state_d = LD_HI;
            LD_HI:   if (accept) state_d = LD_LO;
            LD_LO:   if (accept) state_d = LD_WR;
            LD_WR:   state_d = (cnt_q + CNT_W'(1) == len_q) ? LD_CHK : LD_HI;
            LD_CHK:  if (accept) state_d = LD_IDLE;
            default: state_d = LD_IDLE;
        endcase

        if (tmo_expire) state_d = LD_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            chk_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            tmo_q       <= '0;
            cpu_rst_n_q <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (!counting || accept) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TW'(1);
            end

            case (state_q)
                LD_IDLE: begin
                    if (accept && in_data == SYNC_BYTE) begin
                        cpu_rst_n_q <= 1'b0;
                        err_q       <= 1'b0;
                    end
                end
                LD_LEN: begin
                    if (accept) begin
                        // LEN=0 encodes a full 2**ADDR_W-word image
                        len_q  <= (in_data == 8'h00) ? (CNT_W'(1) << ADDR_W) : CNT_W'(in_data);
                        cnt_q  <= '0;
                        addr_q <= '0;
                        chk_q  <= '0;
                    end
                end
                LD_HI: begin
                    if (accept) begin
                        hi_q  <= in_data;
                        chk_q <= chk_q ^ in_data;
                    end
                end
                LD_LO: begin
                    if (accept) begin
                        lo_q  <= in_data;
                        chk_q <= chk_q ^ in_data;
                    end
                end
                LD_WR: begin
                    addr_q <= addr_q + ADDR_W'(1);
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                LD_CHK: begin
                    if (accept) begin
                        if (in_data == chk_q) begin
                            done_q      <= 1'b1;
                            cpu_rst_n_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (tmo_expire) begin
                err_q       <= 1'b1;
                cpu_rst_n_q <= 1'b0;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = {hi_q, lo_q};
    assign cpu_rst_n = cpu_rst_n_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the CPU instruction-fetch interface: loads a program into the 256x16 instruction RAM that replaces the fixed ROM. The CPU reads this RAM by PC.
- Receives a framed byte stream (from the UART RX / debug link), assembles 16-bit instruction words high byte first, and writes them at consecutive addresses from 0.
- Holds the CPU in reset while loading and releases it only after a frame with a valid checksum.

Parameters:
- ADDR_W, 8, instruction address width; matches the 8-bit PC.
- DATA_W, 16, instruction word width. Fixed at 2 bytes per word.
- TIMEOUT, 1000, maximum idle cycles between bytes inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  byte stream valid
- in_data  in  8  byte stream data
- in_ready  out  1  loader can accept a byte this cycle
- mem_we  out  1  instruction RAM write strobe, one cycle per word
- mem_addr  out  ADDR_W  instruction RAM write address
- mem_wdata  out  DATA_W  instruction RAM write data
- cpu_rst_n  out  1  active-low reset to CPU core
- busy  out  1  a frame is in progress
- done  out  1  one-cycle pulse on a successful load
- err  out  1  sticky error flag

Behaviour:
- Frame format: SYNC=0xA5, LEN (number of words; 0 means 256), 2*LEN payload bytes (hi, lo per word), CHK (XOR of all payload bytes).
- A byte is accepted when in_valid && in_ready are both high on a clk edge.
- Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, busy=0, done=0, err=0. The CPU stays in reset until the first good load.
- States:
  - IDLE: in_ready=1. Any byte other than 0xA5 is discarded. On 0xA5: go to LEN, cpu_rst_n=0, err=0, busy=1.
  - LEN: store word count; clear word counter, address and checksum. Go to HI.
  - HI: latch the high byte and XOR it into the checksum. Go to LO.
  - LO: latch the low byte and XOR it into the checksum. Go to WR.
  - WR: in_ready=0. mem_we=1 for exactly this cycle, with mem_addr = word index and mem_wdata = {hi, lo}. Increment the address (mod 256) and the word counter.
    - Go to CHK when the count reaches LEN (256 when LEN=0); otherwise go to HI.
  - CHK:
    - Match: done=1 for one cycle, cpu_rst_n=1 from the next cycle, busy=0, go to IDLE.
    - Mismatch: err=1, cpu_rst_n stays 0, busy=0, go to IDLE.
- Write latency: mem_we asserts in the cycle after the lo byte is accepted. Data is never written before its lo byte.
- Timeout: an idle counter runs in LEN, HI, LO and CHK. It resets on every accepted byte and does not count in WR or IDLE.
  - Reaching TIMEOUT cycles forces err=1, busy=0, state IDLE, cpu_rst_n=0. Words already written stay in RAM.
- 0xA5 received in HI, LO or CHK is data, not a resync.
- A sync byte in IDLE while the CPU is running re-asserts cpu_rst_n=0 in the next cycle, so a reload is always clean.
- After a failed load, err stays set until the next sync byte.
- A 256-word frame writes addresses 0..255 exactly once. The address wraps to 0 internally but is not written again.
- Asserting rst mid-frame returns all outputs to their reset values immediately. The partial frame is abandoned.

Decomposition:
- Shared package (cpu_pkg): SYNC_BYTE=8'hA5, INSTR_W=16, PC_W=8, loader state encoding (IDLE, LEN, HI, LO, WR, CHK).
- Sub-module: none required. The FSM, counters and checksum fit in one module. The instruction RAM (instr_ram, 256x16, one write port, one async read port on pc) lives in cpu_top, not here.

Test Plan:
- Good frame: stream A5 02 12 34 56 78 08 → writes (0,0x1234), then (1,0x5678). done pulses once, cpu_rst_n=1, err=0.
- Bad checksum: A5 02 12 34 56 78 09 → both words written, err=1, cpu_rst_n=0, no done pulse. A following good frame clears err and releases the CPU.
- Garbage then sync: 00 FF 5A, then the good frame → garbage bytes produce no writes. Load result is identical to the good-frame case.
- LEN=0: A5 00, then 512 bytes where word i = {i, ~i}, then the correct CHK → 256 writes at addresses 0..255 with no duplicate write at address 0. done=1.
- Timeout: A5 01 AB, then in_valid held low for TIMEOUT cycles → err=1 exactly at cycle TIMEOUT, mem_we never asserted, state IDLE.
- Reset mid-frame: rst pulsed after A5 02 12 → all outputs at reset values, no write occurs. A fresh good frame then loads normally.
